regfile_sequencer: RTL and testbench
====================================

# regfile_sequencer

Instruction sequencer for the 32 x 16-bit register file. It accepts one three-operand instruction at a time over a valid/ready handshake and drives the register file's read ports. It computes the result with an internal 16-bit ALU and writes the result back through the write port. It sits between an instruction source (testbench or fetch stage) and the register file, and is the only master of the register file's ports.

## Interface
- DATA_W, 16, datapath and register width
- ADDR_W, 5, register address width (32 registers)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept an instruction
- opcode  in  3  operation select
- rd, rs1, rs2  in  ADDR_W each  destination and source registers
- imm  in  DATA_W  immediate, used by LDI only
- read_adr1, read_adr2  out  ADDR_W  register file read addresses
- read1_valid, read2_valid  out  1  register file read strobes
- read1, read2  in  DATA_W  register file read data, registered inside the register file
- write_adr  out  ADDR_W  register file write address
- data  out  DATA_W  register file write data
- write_valid  out  1  register file write strobe
- done  out  1  one-cycle pulse when an instruction retires
- result  out  DATA_W  value written by the last retired instruction
- busy  out  1  high in every state except IDLE

## Operation
- **Opcodes** (all modulo 2^16, unsigned):
  - 0 ADD: rs1+rs2
  - 1 SUB: rs1-rs2
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL: rs1 << rs2[3:0]
  - 6 SHR: logical, rs1 >> rs2[3:0]
  - 7 LDI: rd <= imm, no reads
- **FSM** states IDLE, READ, EXEC, WRITE.
- **IDLE:** instr_ready=1. On instr_valid&&instr_ready, latch opcode/rd/rs1/rs2/imm.
  - LDI goes directly to WRITE with result=imm.
  - All other opcodes go to READ.
- **READ:** drive read_adr1=rs1 and read_adr2=rs2. Assert read1_valid and read2_valid for exactly this one cycle. Next state EXEC.
- **EXEC:** ALU evaluates combinationally on read1/read2 and the result is registered at the end of the cycle. Next state WRITE.
- **WRITE:** write_valid=1, write_adr=rd, data=result for exactly one cycle. Next state IDLE, with done=1 and result updated in that IDLE cycle.
- **Field sampling:** instruction inputs are sampled only at acceptance. Changes while busy are ignored.
- **rd equal to rs1 or rs2** is legal. Reads complete before the write, so operands are the old values.
- **Register 0** is an ordinary register.

## Timing
- **Reset:** all outputs are registered and reset asynchronously.
  - Strobes, done and busy reset to 0.
  - Addresses, data and result reset to 0.
  - instr_ready reset to 1 (state IDLE).
- **Reset mid-operation:**
  - State returns immediately to IDLE.
  - A pending write is abandoned: write_valid is never asserted, the register file is unchanged, and done is not pulsed.
- **Latency from the acceptance edge:**
  - ALU ops: READ at cycle 1, EXEC at cycle 2, WRITE at cycle 3, done at cycle 4.
  - LDI: WRITE at cycle 1, done at cycle 2.
- **Throughput:**
  - One ALU instruction per 4 cycles with instr_valid held high. The next acceptance happens in the done cycle.
  - LDI: one per 2 cycles.
- **Register file read data** must be stable before the end of the EXEC cycle. Its internal update delay is less than one clock period.
- instr_ready is 0 in READ, EXEC and WRITE.
- done and write_valid are never high in the same cycle.

## Structure
- **Shared package:**
  - Opcode localparams OP_ADD through OP_LDI.
  - State encoding ST_IDLE, ST_READ, ST_EXEC, ST_WRITE.
  - DATA_W and ADDR_W defaults.
- **Sub-module regfile_alu:** purely combinational; inputs opcode, a, b; output y.
- The sequencer FSM and its registers stay in the top module.
- The register file is instantiated beside the sequencer, not inside it.

## Test plan
- **Reset:** assert rst for 3 cycles, then release. Required: all strobes 0, result=0, busy=0, instr_ready=1.
- **LDI then ADD:** LDI r1=0x0005, LDI r2=0x0003, ADD r3=r1+r2. Required: in the WRITE cycle write_adr=3 and data=0x0008; the next cycle has done=1 and result=0x0008.
- **SUB wrap:** SUB r4=r2-r1. Required: data=0xFFFE.
- **AND/OR/XOR** on 0x00F0 and 0x0FF0. Required: 0x00F0, 0x0FF0, 0x0F00.
- **Shifts:**
  - SHL r5=r1<<r2 with r2=3. Required: 0x0028.
  - SHR of 0x8000 with r2=0x0013. Only the shift amount 3 is used. Required: 0x1000.
- **Hazard and back-to-back:** ADD r1=r1+r1 with r1=5 and instr_valid held high with a second instruction queued. Required: data=0x000A; the second instruction is accepted exactly 4 cycles after the first; instr_ready=0 in between.
- **Reset in EXEC:** assert rst during the EXEC of ADD r6=r1+r2. Required: write_valid never rises, done never rises, and a later read shows r6 unchanged.

Source files
------------

// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register-file instruction sequencer:
// default widths, opcode values and FSM state encoding.
package regfile_sequencer_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 5;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_LDI = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Instruction channel into the sequencer: valid/ready handshake plus the
// three-operand instruction fields and the LDI immediate.
interface regfile_sequencer_if
    import regfile_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] imm;

    modport master (
        output instr_valid, opcode, rd, rs1, rs2, imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, opcode, rd, rs1, rs2, imm,
        output instr_ready
    );

endinterface

// File: rtl/regfile_sequencer_alu.sv
// Combinational 16-bit ALU used during the EXEC state; all results wrap
// modulo 2^DATA_W and shifts use only the low bits of b.
module regfile_alu
    import regfile_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    localparam int SH_W = $clog2(DATA_W);

    always_comb begin
        y = '0;
        case (opcode)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SHL:  y = a << b[SH_W-1:0];
            OP_SHR:  y = a >> b[SH_W-1:0];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Instruction sequencer: accepts one instruction, reads the external register
// file, runs the ALU and writes the result back. All outputs are registered.
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    regfile_sequencer_if.slave  instr,
    output logic [ADDR_W-1:0]   read_adr1,
    output logic [ADDR_W-1:0]   read_adr2,
    output logic                read1_valid,
    output logic                read2_valid,
    input  logic [DATA_W-1:0]   read1,
    input  logic [DATA_W-1:0]   read2,
    output logic [ADDR_W-1:0]   write_adr,
    output logic [DATA_W-1:0]   data,
    output logic                write_valid,
    output logic                done,
    output logic [DATA_W-1:0]   result,
    output logic                busy
);

    state_t            state;
    state_t            next_state;
    logic              instr_ready_q;
    logic              accept;
    logic [2:0]        opcode_q;
    logic [DATA_W-1:0] alu_y;

    logic              nxt_ready;
    logic              nxt_read_valid;
    logic              nxt_write_valid;
    logic              nxt_done;
    logic              nxt_busy;
    logic [ADDR_W-1:0] nxt_read_adr1;
    logic [ADDR_W-1:0] nxt_read_adr2;
    logic [ADDR_W-1:0] nxt_write_adr;
    logic [DATA_W-1:0] nxt_data;
    logic [DATA_W-1:0] nxt_result;

    assign accept            = instr.instr_valid && instr_ready_q;
    assign instr.instr_ready = instr_ready_q;

    regfile_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode (opcode_q),
        .a      (read1),
        .b      (read2),
        .y      (alu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept) next_state = (instr.opcode == OP_LDI) ? ST_WRITE : ST_READ;
            ST_READ:  next_state = ST_EXEC;
            ST_EXEC:  next_state = ST_WRITE;
            ST_WRITE: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output values are decoded from the upcoming state so every port is a flop.
    always_comb begin
        nxt_ready       = (next_state == ST_IDLE);
        nxt_read_valid  = (next_state == ST_READ);
        nxt_write_valid = (next_state == ST_WRITE);
        nxt_busy        = (next_state != ST_IDLE);
        nxt_done        = (state == ST_WRITE);
        nxt_read_adr1   = accept ? instr.rs1 : read_adr1;
        nxt_read_adr2   = accept ? instr.rs2 : read_adr2;
        nxt_write_adr   = accept ? instr.rd  : write_adr;
        nxt_data        = data;
        if (accept && instr.opcode == OP_LDI) begin
            nxt_data = instr.imm;
        end else if (state == ST_EXEC) begin
            nxt_data = alu_y;
        end
        nxt_result      = (state == ST_WRITE) ? data : result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_ready_q <= 1'b1;
            read1_valid   <= 1'b0;
            read2_valid   <= 1'b0;
            write_valid   <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            read_adr1     <= '0;
            read_adr2     <= '0;
            write_adr     <= '0;
            data          <= '0;
            result        <= '0;
        end else begin
            instr_ready_q <= nxt_ready;
            read1_valid   <= nxt_read_valid;
            read2_valid   <= nxt_read_valid;
            write_valid   <= nxt_write_valid;
            done          <= nxt_done;
            busy          <= nxt_busy;
            read_adr1     <= nxt_read_adr1;
            read_adr2     <= nxt_read_adr2;
            write_adr     <= nxt_write_adr;
            data          <= nxt_data;
            result        <= nxt_result;
        end
    end

    // Opcode is only needed by the ALU; it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) opcode_q <= instr.opcode;
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a behavioural register file sits beside the
// DUT and an array-based reference model predicts every write-back.
module tb_regfile_sequencer;
    import regfile_sequencer_pkg::*;

    localparam int DW = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] read_adr1, read_adr2, write_adr;
    logic          read1_valid, read2_valid, write_valid, done, busy;
    logic [DW-1:0] read1 = '0;
    logic [DW-1:0] read2 = '0;
    logic [DW-1:0] data, result;
    logic [DW-1:0] regs [32] = '{default: '0};

    int total = 0;
    int bad   = 0;
    int model [32];

    int            w_cycle, d_cycle, wv_cnt;
    logic [AW-1:0] w_adr;
    logic [DW-1:0] w_data, res;
    logic          overlap, ready_bad;

    regfile_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) instr_if ();

    regfile_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr_if),
        .read_adr1   (read_adr1),
        .read_adr2   (read_adr2),
        .read1_valid (read1_valid),
        .read2_valid (read2_valid),
        .read1       (read1),
        .read2       (read2),
        .write_adr   (write_adr),
        .data        (data),
        .write_valid (write_valid),
        .done        (done),
        .result      (result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Register file with registered read data.
    always @(posedge clk) begin
        if (read1_valid) read1 <= regs[read_adr1];
        if (read2_valid) read2 <= regs[read_adr2];
        if (write_valid) regs[write_adr] <= data;
    end

    function automatic int alu_ref(input int op, input int a, input int b);
        longint sh;
        sh = longint'(1) << (b % 16);
        case (op)
            0: return (a + b) % 65536;
            1: return (a - b + 65536) % 65536;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return int'((longint'(a) * sh) % 65536);
            6: return int'(longint'(a) / sh);
            default: return 0;
        endcase
    endfunction

    // Issues one instruction and records what the DUT did; updates the model.
    task automatic run_instr(input logic [2:0] op, input int rdv, input int r1,
                             input int r2, input logic [15:0] immv);
        int n;
        instr_if.opcode      = op;
        instr_if.rd          = 5'(rdv);
        instr_if.rs1         = 5'(r1);
        instr_if.rs2         = 5'(r2);
        instr_if.imm         = immv;
        instr_if.instr_valid = 1'b1;
        n = 0;
        while (!instr_if.instr_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        instr_if.instr_valid = 1'b0;
        w_cycle = -1; d_cycle = -1; wv_cnt = 0; overlap = 1'b0; ready_bad = 1'b0;
        w_adr = '0; w_data = '0; res = '0;
        for (int c = 1; c <= 10; c++) begin
            if (write_valid) begin
                wv_cnt++; w_cycle = c; w_adr = write_adr; w_data = data;
            end
            if (write_valid && done) overlap = 1'b1;
            if (done) begin
                d_cycle = c; res = result;
                break;
            end
            if (instr_if.instr_ready) ready_bad = 1'b1;
            @(posedge clk); #1;
        end
        if (op == OP_LDI) model[rdv] = int'(immv);
        else              model[rdv] = alu_ref(int'(op), model[r1], model[r2]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy_during got=%b want=0", busy); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total++; if ({read1_valid, read2_valid, write_valid, done} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes got=%b want=0000", {read1_valid, read2_valid, write_valid, done}); end
        total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h want=0000", result); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (instr_if.instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", instr_if.instr_ready); end
        total++; if ({data, write_adr, read_adr1, read_adr2} !== '0) begin
            bad++; $display("FAIL reset_buses got=%h want=0", {data, write_adr, read_adr1, read_adr2}); end
    endtask

    task automatic test_ldi_add();
        run_instr(OP_LDI, 1, 0, 0, 16'h0005);
        total++; if (w_data !== 16'h0005) begin bad++; $display("FAIL ldi_data got=%h want=0005", w_data); end
        total++; if (w_cycle !== 1) begin bad++; $display("FAIL ldi_write_latency got=%0d want=1", w_cycle); end
        total++; if (d_cycle !== 2) begin bad++; $display("FAIL ldi_done_latency got=%0d want=2", d_cycle); end
        run_instr(OP_LDI, 2, 0, 0, 16'h0003);
        run_instr(OP_ADD, 3, 1, 2, 16'hDEAD);
        total++; if (w_adr !== 5'd3) begin bad++; $display("FAIL add_write_adr got=%0d want=3", w_adr); end
        total++; if (w_data !== 16'h0008) begin bad++; $display("FAIL add_data got=%h want=0008", w_data); end
        total++; if (w_cycle !== 3) begin bad++; $display("FAIL add_write_latency got=%0d want=3", w_cycle); end
        total++; if (d_cycle !== 4) begin bad++; $display("FAIL add_done_latency got=%0d want=4", d_cycle); end
        total++; if (res !== 16'h0008) begin bad++; $display("FAIL add_result got=%h want=0008", res); end
        total++; if (wv_cnt !== 1) begin bad++; $display("FAIL add_write_pulses got=%0d want=1", wv_cnt); end
        total++; if (overlap !== 1'b0) begin bad++; $display("FAIL add_done_write_overlap got=%b want=0", overlap); end
        total++; if (ready_bad !== 1'b0) begin bad++; $display("FAIL add_ready_while_busy got=%b want=0", ready_bad); end
    endtask

    task automatic test_sub_wrap();
        run_instr(OP_SUB, 4, 2, 1, 16'h0000);
        total++; if (w_data !== 16'hFFFE) begin bad++; $display("FAIL sub_wrap got=%h want=FFFE", w_data); end
        total++; if (res !== 16'hFFFE) begin bad++; $display("FAIL sub_result got=%h want=FFFE", res); end
    endtask

    task automatic test_logic();
        logic [2:0]  ops [3];
        logic [15:0] exp [3];
        ops = '{OP_AND, OP_OR, OP_XOR};
        exp = '{16'h00F0, 16'h0FF0, 16'h0F00};
        run_instr(OP_LDI, 10, 0, 0, 16'h00F0);
        run_instr(OP_LDI, 11, 0, 0, 16'h0FF0);
        for (int i = 0; i < 3; i++) begin
            run_instr(ops[i], 12 + i, 10, 11, 16'h0000);
            total++; if (w_data !== exp[i]) begin bad++; $display("FAIL logic_op%0d got=%h want=%h", ops[i], w_data, exp[i]); end
        end
    endtask

    task automatic test_shift();
        run_instr(OP_SHL, 5, 1, 2, 16'h0000);
        total++; if (w_data !== 16'h0028) begin bad++; $display("FAIL shl got=%h want=0028", w_data); end
        run_instr(OP_LDI, 9, 0, 0, 16'h8000);
        run_instr(OP_LDI, 2, 0, 0, 16'h0013);
        run_instr(OP_SHR, 15, 9, 2, 16'h0000);
        total++; if (w_data !== 16'h1000) begin bad++; $display("FAIL shr got=%h want=1000", w_data); end
    endtask

    task automatic test_back_to_back();
        int acc;
        int n;
        logic [15:0] first_data;
        logic [15:0] exp2;
        logic        rb;
        run_instr(OP_LDI, 1, 0, 0, 16'h0005);
        instr_if.opcode = OP_ADD; instr_if.rd = 5'd1; instr_if.rs1 = 5'd1; instr_if.rs2 = 5'd1;
        instr_if.instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_if.opcode = OP_SUB; instr_if.rd = 5'd8; instr_if.rs1 = 5'd1; instr_if.rs2 = 5'd2;
        acc = -1; first_data = '0;
        for (int c = 1; c <= 8; c++) begin
            if (write_valid) first_data = data;
            if (instr_if.instr_ready) begin acc = c; break; end
            @(posedge clk); #1;
        end
        model[1] = alu_ref(0, model[1], model[1]);
        exp2 = 16'(alu_ref(1, model[1], model[2]));
        total++; if (acc !== 4) begin bad++; $display("FAIL b2b_accept_gap got=%0d want=4", acc); end
        total++; if (first_data !== 16'h000A) begin bad++; $display("FAIL b2b_hazard_data got=%h want=000A", first_data); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done_at_accept got=%b want=1", done); end
        @(posedge clk); #1;
        instr_if.instr_valid = 1'b0;
        total++; if ({read1_valid, instr_if.instr_ready, read_adr1} !== {1'b1, 1'b0, 5'd1}) begin
            bad++; $display("FAIL b2b_second_read got=%b/%b/%0d want=1/0/1", read1_valid, instr_if.instr_ready, read_adr1); end
        rb = 1'b0; n = 0;
        while (!write_valid && n < 10) begin
            if (instr_if.instr_ready) rb = 1'b1;
            @(posedge clk); #1; n++;
        end
        total++; if (data !== exp2 || write_adr !== 5'd8 || !write_valid) begin
            bad++; $display("FAIL b2b_second_data got=%h@%0d want=%h@8", data, write_adr, exp2); end
        total++; if (rb !== 1'b0) begin bad++; $display("FAIL b2b_ready_while_busy got=%b want=0", rb); end
        model[8] = int'(exp2);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_exec();
        logic seen;
        run_instr(OP_LDI, 6, 0, 0, 16'h1234);
        instr_if.opcode = OP_ADD; instr_if.rd = 5'd6; instr_if.rs1 = 5'd1; instr_if.rs2 = 5'd2;
        instr_if.instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_if.instr_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rexec_busy_before got=%b want=1", busy); end
        rst = 1'b1;
        #1;
        total++; if ({instr_if.instr_ready, busy, write_valid} !== 3'b100) begin
            bad++; $display("FAIL rexec_async got=%b want=100", {instr_if.instr_ready, busy, write_valid}); end
        seen = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (c == 3) rst = 1'b0;
            @(posedge clk); #1;
            if (write_valid || done) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rexec_strobe_after_reset got=%b want=0", seen); end
        total++; if (regs[6] !== 16'h1234) begin bad++; $display("FAIL rexec_r6_array got=%h want=1234", regs[6]); end
        run_instr(OP_OR, 7, 6, 6, 16'h0000);
        total++; if (w_data !== 16'h1234) begin bad++; $display("FAIL rexec_r6_read got=%h want=1234", w_data); end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        int          rdv, r1, r2, expw, expd;
        logic [15:0] immv, exp;
        for (int i = 0; i < 40; i++) begin
            op   = 3'($urandom_range(0, 7));
            rdv  = int'($urandom_range(0, 31));
            r1   = int'($urandom_range(0, 31));
            r2   = int'($urandom_range(0, 31));
            immv = 16'($urandom);
            exp  = (op == OP_LDI) ? immv : 16'(alu_ref(int'(op), model[r1], model[r2]));
            expw = (op == OP_LDI) ? 1 : 3;
            expd = expw + 1;
            run_instr(op, rdv, r1, r2, immv);
            total++; if (w_data !== exp || w_adr !== 5'(rdv)) begin
                bad++; $display("FAIL rand%0d_write op=%0d got=%h@%0d want=%h@%0d", i, op, w_data, w_adr, exp, rdv); end
            total++; if (w_cycle !== expw || d_cycle !== expd) begin
                bad++; $display("FAIL rand%0d_latency got=%0d/%0d want=%0d/%0d", i, w_cycle, d_cycle, expw, expd); end
            total++; if (res !== exp) begin bad++; $display("FAIL rand%0d_result got=%h want=%h", i, res, exp); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 0;
        instr_if.instr_valid = 1'b0;
        instr_if.opcode = '0; instr_if.rd = '0; instr_if.rs1 = '0; instr_if.rs2 = '0; instr_if.imm = '0;
        test_reset();
        test_ldi_add();
        test_sub_wrap();
        test_logic();
        test_shift();
        test_back_to_back();
        test_reset_exec();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
